sim_test_status: RTL and testbench
==================================

// Module: sim_test_status
// PURPOSE
//   Memory-mapped responder on the core data bus that gives programs a
//   hardware end-of-test channel in the RV32-core design.
//   Target-program stores to TOHOST finish the test with pass or fail; a
//   hardware cycle counter and watchdog provide the timeout.
//   Sits beside data memory in top; the bench watches done/pass instead of
//   relying on a fixed cycle limit.
// PARAMETERS
//   BASE_ADDR       32'h1000_0000  byte base of 32-byte register window (32B aligned)
//   TIMEOUT_CYCLES  1000           watchdog limit in RUN cycles; 0 disables watchdog
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous reset, active-low (0 = reset)
//   req        in   1   bus request, one beat per cycle
//   we         in   1   1 = store, 0 = load
//   addr       in   32  byte address
//   wdata      in   32  store data
//   wstrb      in   4   byte enables for stores
//   rvalid     out  1   load response valid, exactly 1 cycle after accepted load
//   rdata      out  32  load data, valid when rvalid
//   done       out  1   test finished (PASS, FAIL or TIMEOUT), sticky
//   pass       out  1   finished with pass, sticky
//   timeout    out  1   watchdog fired, sticky
//   fail_code  out  31  TOHOST value >> 1 on FAIL, else 0
//   con_valid  out  1   console byte strobe, 1-cycle pulse
//   con_data   out  8   console byte, valid when con_valid
// BEHAVIOUR
//   Reset: all outputs 0, state RUN, cycle counter 0.
//   Select: hit = req && addr[31:5] == BASE_ADDR[31:5]; no hit -> no response, no effect.
//   Always ready: every hit is accepted in the cycle presented; no stall.
//   Register map (offset = addr[4:0]; addr[1:0] ignored):
//     0x00 TOHOST   W: full-word stores only (wstrb==4'hF); other wstrb ignored.
//     0x04 CYCLE_LO R: cycle_cnt[31:0].
//     0x08 CYCLE_HI R: cycle_cnt[63:32].
//     0x0C STATUS   R: {fail_code[28:0], timeout, pass, done}.
//     0x10 CONSOLE  W: if wstrb[0], next cycle con_valid=1, con_data=wdata[7:0].
//     others: stores ignored; loads return 0 with rvalid.
//   Loads: rvalid/rdata registered, 1-cycle latency; rdata holds its last value when !rvalid.
//     Loads of TOHOST return last accepted TOHOST value (0 after reset).
//   Stores to read-only offsets are ignored; loads of CONSOLE return 0.
//   State machine (TIMEOUT_CYCLES abbreviated T):
//     RUN   : TOHOST store v==1 -> PASS; v odd, v!=1 -> FAIL (fail_code=v>>1);
//             v even -> stay RUN, value still stored;
//             T!=0 && cycle_cnt==T-1 -> TIMEOUT.
//     PASS/FAIL/TIMEOUT: terminal, left only by reset; TOHOST stores ignored.
//   done/pass/timeout/fail_code registered: change the cycle after the
//     causing store/count.
//   Simultaneous TOHOST store and watchdog expiry in the same cycle: store wins.
//   cycle_cnt: 64-bit, +1 each cycle in RUN, frozen in terminal states,
//     wraps 2^64-1 -> 0 without effect.
//   Loads, console and CYCLE reads remain fully serviced in terminal states.
//   Load and console pulse in flight when rst falls: cancelled, outputs forced to 0 immediately.
// TESTING
//   Reset, 5 idle clocks, load 0x04 -> rvalid next cycle, rdata==5 (+/-1 per counting edge); done==0.
//   Store 0x00 = 32'h1 -> next cycle done=1, pass=1; load 0x0C returns 32'h3; CYCLE_LO frozen.
//   Store 0x00 = 32'h7 -> done=1, pass=0, fail_code=3; later store 32'h1 ignored, pass stays 0.
//   TIMEOUT_CYCLES=20, no stores -> done=timeout=1 after 20 RUN cycles; same-cycle store 1 -> PASS.
//   Store 0x10 wdata=32'h41 wstrb=4'h1 -> con_valid 1 cycle, con_data=8'h41; addr BASE+0x40 -> no rvalid.
//   TOHOST store with wstrb=4'h3 ignored; rst low while rvalid pending -> rvalid 0, state RUN, counter 0.

Source files
------------

// File: rtl/sim_test_status.sv
// End-of-test responder on the core data bus: TOHOST pass/fail, a free-running
// RUN-cycle counter with watchdog, and a console byte port.
module sim_test_status #(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic        con_valid,
  output logic [7:0]  con_data
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [63:0] WD_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

  localparam logic [2:0] OFF_TOHOST  = 3'd0;
  localparam logic [2:0] OFF_CYCLE_L = 3'd1;
  localparam logic [2:0] OFF_CYCLE_H = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_CONSOLE = 3'd4;

  state_e      state_q, state_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] tohost_q, tohost_d;
  logic [30:0] fail_code_q, fail_code_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        con_valid_q, con_valid_d;
  logic [7:0]  con_data_q, con_data_d;

  logic        hit;
  logic [2:0]  offset;
  logic        tohost_wr;
  logic        wd_fire;
  logic [31:0] status_word;
  logic        unused_addr_lsb;

  assign hit             = req && (addr[31:5] == BASE_ADDR[31:5]);
  assign offset          = addr[4:2];
  assign tohost_wr       = hit && we && (offset == OFF_TOHOST) && (wstrb == 4'hF);
  assign wd_fire         = WD_EN && (cycle_q == WD_LAST);
  assign unused_addr_lsb = ^addr[1:0];

  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign fail_code   = fail_code_q;
  assign status_word = {fail_code_q[28:0], timeout, pass, done};

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    tohost_d    = tohost_q;
    fail_code_d = fail_code_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;

    if (state_q == ST_RUN) begin
      cycle_d = cycle_q + 64'd1;
      if (tohost_wr) begin
        tohost_d = wdata;
      end
      // A terminating store outranks a watchdog expiry in the same cycle;
      // an even store does not terminate, so the watchdog may still fire.
      if (tohost_wr && wdata[0]) begin
        if (wdata == 32'd1) begin
          state_d = ST_PASS;
        end else begin
          state_d     = ST_FAIL;
          fail_code_d = wdata[31:1];
        end
      end else if (wd_fire) begin
        state_d = ST_TIMEOUT;
      end
    end

    if (hit && !we) begin
      rvalid_d = 1'b1;
      case (offset)
        OFF_TOHOST:  rdata_d = tohost_q;
        OFF_CYCLE_L: rdata_d = cycle_q[31:0];
        OFF_CYCLE_H: rdata_d = cycle_q[63:32];
        OFF_STATUS:  rdata_d = status_word;
        default:     rdata_d = 32'd0;
      endcase
    end

    if (hit && we && (offset == OFF_CONSOLE) && wstrb[0]) begin
      con_valid_d = 1'b1;
      con_data_d  = wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cycle_q     <= 64'd0;
      tohost_q    <= 32'd0;
      fail_code_q <= 31'd0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      con_valid_q <= 1'b0;
      con_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      tohost_q    <= tohost_d;
      fail_code_q <= fail_code_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;

endmodule

// File: tb/tb_sim_test_status.sv
// Scoreboard bench for sim_test_status: a transaction-level model predicts load
// data, console bytes and end-of-test status; a monitor compares on each negedge.
module tb_sim_test_status;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          T    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] fail_code;
  logic        con_valid;
  logic [7:0]  con_data;

  sim_test_status #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rvalid(rvalid), .rdata(rdata), .done(done), .pass(pass),
    .timeout(timeout), .fail_code(fail_code), .con_valid(con_valid),
    .con_data(con_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: 0=running, 1=passed, 2=failed, 3=timed out
  int          m_state  = 0;
  logic [63:0] m_cnt    = 64'd0;
  logic [31:0] m_tohost = 32'd0;
  logic [30:0] m_fail   = 31'd0;
  logic [31:0] rd_q[$];
  logic [7:0]  con_q[$];

  always @(negedge rst) begin
    m_state  = 0;
    m_cnt    = 64'd0;
    m_tohost = 32'd0;
    m_fail   = 31'd0;
    rd_q.delete();
    con_q.delete();
  end

  always @(posedge clk) begin
    logic hit;
    int   off;
    if (rst) begin
      hit = req && (addr[31:5] == BASE[31:5]);
      off = int'(addr[4:2]);
      if (hit && !we) begin
        case (off)
          0:       rd_q.push_back(m_tohost);
          1:       rd_q.push_back(m_cnt[31:0]);
          2:       rd_q.push_back(m_cnt[63:32]);
          3:       rd_q.push_back({m_fail[28:0], m_state == 3, m_state == 1, m_state != 0});
          default: rd_q.push_back(32'd0);
        endcase
      end
      if (hit && we && off == 4 && wstrb[0]) con_q.push_back(wdata[7:0]);
      if (m_state == 0) begin
        if (hit && we && off == 0 && wstrb == 4'hF) begin
          m_tohost = wdata;
          if (wdata == 32'd1) m_state = 1;
          else if (wdata % 2 == 1) begin
            m_state = 2;
            m_fail  = wdata[31:1];
          end
        end
        if (m_state == 0 && T != 0 && m_cnt == 64'(T - 1)) m_state = 3;
        m_cnt = m_cnt + 64'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    logic [7:0]  ec;
    if (rst) begin
      chk("rvalid", rvalid, rd_q.size() != 0);
      if (rd_q.size() != 0) begin
        er = rd_q.pop_front();
        if (rvalid) chk("rdata", rdata, er);
      end
      chk("con_valid", con_valid, con_q.size() != 0);
      if (con_q.size() != 0) begin
        ec = con_q.pop_front();
        if (con_valid) chk("con_data", con_data, ec);
      end
      chk("done", done, m_state != 0);
      chk("pass", pass, m_state == 1);
      chk("timeout", timeout, m_state == 3);
      chk("fail_code", fail_code, m_fail);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_rvalid", rvalid, 0);
    chk("rst_con_valid", con_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_code", fail_code, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic rand_beat();
    int k;
    req = ($urandom_range(0, 9) < 7);
    we  = $urandom_range(0, 1) == 1;
    k   = $urandom_range(0, 9);
    if (k == 0)      addr = BASE + 32'h40 + 32'($urandom_range(0, 31));
    else if (k == 1) addr = $urandom;
    else             addr = BASE + 32'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0:       wdata = 32'd1;
      1:       wdata = $urandom | 32'd1;
      2:       wdata = $urandom & ~32'd1;
      default: wdata = $urandom;
    endcase
    wstrb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // idle counting, then pass
    idle(5);
    beat(1'b0, BASE + 32'h04, 32'd0, 4'h0);
    chk("cycle_lo_after_idle", (rdata >= 32'd5 && rdata <= 32'd7), 1);
    beat(1'b1, BASE + 32'h00, 32'h1, 4'hF);
    chk("pass_done", done, 1);
    chk("pass_pass", pass, 1);
    beat(1'b0, BASE + 32'h0C, 32'd0, 4'h0);
    chk("status_pass", rdata, 32'h3);
    beat(1'b0, BASE + 32'h04, 32'd0, 4'h0);
    idle(3);
    beat(1'b0, BASE + 32'h04, 32'd0, 4'h0);
    idle(1);

    // fail code, later pass ignored
    do_reset();
    beat(1'b1, BASE + 32'h00, 32'h7, 4'hF);
    chk("fail_code_3", fail_code, 31'd3);
    chk("fail_pass", pass, 0);
    beat(1'b1, BASE + 32'h00, 32'h1, 4'hF);
    beat(1'b0, BASE + 32'h0C, 32'd0, 4'h0);
    chk("status_fail", rdata, 32'h19);
    chk("fail_sticky_pass", pass, 0);
    beat(1'b0, BASE + 32'h00, 32'd0, 4'h0);
    chk("tohost_readback", rdata, 32'h7);

    // watchdog fires after T run cycles
    do_reset();
    idle(T - 2);
    chk("no_timeout_yet", timeout, 0);
    idle(1);
    chk("timeout_fired", timeout, 1);
    chk("timeout_done", done, 1);
    beat(1'b0, BASE + 32'h08, 32'd0, 4'h0);
    beat(1'b0, BASE + 32'h04, 32'd0, 4'h0);
    chk("cycle_frozen_at_T", rdata, 32'(T));

    // store on the expiry cycle wins
    do_reset();
    idle(T - 2);
    beat(1'b1, BASE + 32'h00, 32'h1, 4'hF);
    chk("store_beats_wd_pass", pass, 1);
    chk("store_beats_wd_to", timeout, 0);

    // console, out-of-window, partial TOHOST store
    do_reset();
    beat(1'b1, BASE + 32'h10, 32'h41, 4'h1);
    chk("con_strobe", con_valid, 1);
    chk("con_byte", con_data, 8'h41);
    beat(1'b0, BASE + 32'h40, 32'd0, 4'h0);
    chk("no_rvalid_outside", rvalid, 0);
    beat(1'b1, BASE + 32'h00, 32'h1, 4'h3);
    chk("partial_store_ignored", done, 0);
    beat(1'b0, BASE + 32'h10, 32'd0, 4'h0);
    chk("console_reads_zero", rdata, 0);

    // reset with a load response pending
    req = 1'b1; we = 1'b0; addr = BASE + 32'h04;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 1'b0;
    #1 chk("rst_cancels_rvalid", rvalid, 0);
    chk("rst_clears_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    beat(1'b0, BASE + 32'h04, 32'd0, 4'h0);
    chk("counter_restarted", (rdata <= 32'd2), 1);

    // reset with a console strobe pending
    req = 1'b1; we = 1'b1; addr = BASE + 32'h10; wdata = 32'h5A; wstrb = 4'h1;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 1'b0;
    #1 chk("rst_cancels_con", con_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // randomized traffic against the model
    for (int r = 0; r < 10; r++) begin
      do_reset();
      for (int i = 0; i < 40; i++) rand_beat();
      idle(2);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
